twiddle_seq: RTL and testbench

Sequencer that turns one start pulse from the local-bus interface into a table of eight powers of a twiddle factor modulo Q, driving an external pipelined 12-bit modular multiplier. It sits between the bus interface registers (operands `a`, `b`; `blk_krdy`/`blk_drdy`/`blk_en`/`blk_rstn`) and the NTT multiplier core, and returns the packed result on `blk_dout` with a `blk_dvld` pulse.

---
 rtl/twiddle_seq.sv | 108 ++++++++++
 tb/tb_twiddle_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_seq.sv
// Twiddle power sequencer: builds t0..t7 = t0*w^k mod Q by issuing seven serial
// requests to an external pipelined modular multiplier.
module twiddle_seq #(
  parameter logic [11:0] Q = 12'd3329
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [11:0]  a_in,
  input  logic [11:0]  b_in,
  input  logic         blk_krdy,
  input  logic         blk_drdy,
  input  logic         blk_en,
  input  logic         blk_rstn,
  output logic         blk_kvld,
  output logic         blk_dvld,
  output logic [127:0] blk_dout,
  output logic         busy,
  output logic         mul_start,
  output logic [11:0]  mul_x,
  output logic [11:0]  mul_y,
  input  logic [11:0]  mul_res,
  input  logic         mul_vld
);

  // state | meaning
  // IDLE  | waiting for start / twiddle load
  // ISSUE | presenting t(k), w to the multiplier when enabled
  // WAIT  | one multiply in flight, waiting for its result
  // DONE  | table complete, one-cycle valid pulse
  // DRAIN | aborted with a multiply in flight; swallow its result
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t      state, state_nx;
  logic [11:0] w;
  logic [11:0] lane [8];
  logic [2:0]  k;

  function automatic logic [11:0] red(input logic [11:0] x);
    return (x >= Q) ? x - Q : x;
  endfunction

  always_comb begin
    state_nx = state;
    if (!blk_rstn) begin
      state_nx = (state == WAIT || state == DRAIN) ? DRAIN : IDLE;
    end else begin
      case (state)
        IDLE:    if (blk_drdy) state_nx = ISSUE;
        ISSUE:   if (blk_en) state_nx = WAIT;
        WAIT:    if (mul_vld) state_nx = (k == 3'd6) ? DONE : ISSUE;
        DONE:    state_nx = IDLE;
        DRAIN:   if (mul_vld) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // An abort in ISSUE must not launch a request it would never collect.
  always_comb begin
    mul_start = (state == ISSUE) && blk_en && blk_rstn;
    mul_x     = mul_start ? lane[k] : 12'd0;
    mul_y     = mul_start ? w : 12'd0;
    blk_dvld  = (state == DONE) && blk_rstn;
    busy      = (state != IDLE);
  end

  always_comb begin
    blk_dout = '0;
    for (int i = 0; i < 8; i++) begin
      blk_dout[127-16*i -: 16] = {4'h0, lane[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      w        <= 12'd0;
      k        <= 3'd0;
      blk_kvld <= 1'b0;
      for (int i = 0; i < 8; i++) lane[i] <= 12'd0;
    end else begin
      state    <= state_nx;
      blk_kvld <= (state == IDLE) && blk_krdy && blk_rstn;
      if (!blk_rstn) begin
        for (int i = 0; i < 8; i++) lane[i] <= 12'd0;
      end else begin
        case (state)
          IDLE: begin
            if (blk_krdy) w <= red(b_in);
            if (blk_drdy) begin
              lane[0] <= red(a_in);
              for (int i = 1; i < 8; i++) lane[i] <= 12'd0;
              k <= 3'd0;
            end
          end
          WAIT: begin
            if (mul_vld) begin
              lane[k + 3'd1] <= mul_res;
              if (k != 3'd6) k <= k + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq with a behavioural multiplier of programmable latency.
module tb_twiddle_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [11:0]  a_in = '0, b_in = '0;
  logic         blk_krdy = 1'b0, blk_drdy = 1'b0, blk_en = 1'b1, blk_rstn = 1'b1;
  logic         blk_kvld, blk_dvld, busy, mul_start, mul_vld;
  logic [127:0] blk_dout;
  logic [11:0]  mul_x, mul_y, mul_res;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] EXP17 = 128'h0001_0011_0121_0630_0128_06A7_090F_0AF4;
  localparam logic [127:0] EXPW0 = 128'h02FE_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [127:0] EXP3  = 128'h0002_0006_0012_0036_00A2_01E6_05B2_0415;

  twiddle_seq dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .blk_krdy(blk_krdy), .blk_drdy(blk_drdy), .blk_en(blk_en), .blk_rstn(blk_rstn),
    .blk_kvld(blk_kvld), .blk_dvld(blk_dvld), .blk_dout(blk_dout), .busy(busy),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_res(mul_res), .mul_vld(mul_vld)
  );

  always #5 clk = ~clk;

  // Multiplier core: one result mul_lat cycles after each request.
  int          mul_lat = 1;
  int          cnt;
  logic [11:0] pend;
  logic        man_vld = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 0;
      pend <= 12'd0;
    end else if (mul_start) begin
      cnt  <= mul_lat;
      pend <= 12'((32'(mul_x) * 32'(mul_y)) % 3329);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  assign mul_vld = (cnt == 1) || man_vld;
  assign mul_res = pend;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic load_w(input logic [11:0] b);
    b_in = b;
    blk_krdy = 1'b1;
    @(negedge clk);
    blk_krdy = 1'b0;
    #1;
    chk("kvld_pulse", blk_kvld, 1);
    @(negedge clk);
    chk("kvld_single", blk_kvld, 0);
  endtask

  // Called at a negedge in IDLE; cycle 0 is the blk_drdy cycle.
  task automatic run_job(input logic [11:0] a, input bit with_k, input logic [11:0] b,
                         input int lat, input int lo_from, input int lo_cnt,
                         input int inj_cyc, input logic [11:0] exp_w,
                         output int dvld_cyc, output logic [127:0] dout_v);
    int c, ndv, nst;
    mul_lat = lat;
    a_in = a;
    blk_drdy = 1'b1;
    if (with_k) begin
      b_in = b;
      blk_krdy = 1'b1;
    end
    @(negedge clk);
    c = 1; ndv = 0; nst = 0; dvld_cyc = -1; dout_v = '0;
    while (c < 120) begin
      blk_en = !(c >= lo_from && c < lo_from + lo_cnt);
      if (c == inj_cyc) begin
        a_in = 12'd9; b_in = 12'd5; blk_drdy = 1'b1; blk_krdy = 1'b1;
      end else begin
        blk_drdy = 1'b0; blk_krdy = 1'b0;
      end
      #1;
      if (c == 1) chk("busy_rise", busy, 1);
      chk("kvld", blk_kvld, (with_k && c == 1));
      if (mul_start) begin
        nst++;
        chk("mul_y", mul_y, exp_w);
      end
      if (dvld_cyc >= 0) begin
        chk("busy_fall", busy, 0);
        chk("dvld_once", blk_dvld, 0);
        break;
      end
      if (blk_dvld) begin
        ndv++;
        dvld_cyc = c;
        dout_v = blk_dout;
      end
      @(negedge clk);
      c++;
    end
    blk_drdy = 1'b0; blk_krdy = 1'b0; blk_en = 1'b1;
    chk("dvld_count", ndv, 1);
    chk("mul_starts", nst, 7);
  endtask

  initial begin
    int dc, ndv;
    logic [127:0] dv;

    #1;
    chk("rst_dout", blk_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_kvld", blk_kvld, 0);
    chk("rst_dvld", blk_dvld, 0);
    chk("rst_mul", {mul_start, mul_x, mul_y}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    load_w(12'd17);
    run_job(12'd1, 0, 0, 1, -1, 0, -1, 12'd17, dc, dv);
    chk("w17_latency", dc, 15);
    chk("w17_dout", dv, EXP17);

    load_w(12'd3329);
    run_job(12'd4095, 0, 0, 1, -1, 0, -1, 12'd0, dc, dv);
    chk("w0_latency", dc, 15);
    chk("w0_dout", dv, EXPW0);

    load_w(12'd17);
    run_job(12'd1, 0, 0, 4, 6, 3, -1, 12'd17, dc, dv);
    chk("l4_stall_latency", dc, 39);
    chk("l4_stall_dout", dv, EXP17);

    // Abort in WAIT of third multiply; core answers two cycles later.
    mul_lat = 6;
    a_in = 12'd1;
    blk_drdy = 1'b1;
    @(negedge clk);
    blk_drdy = 1'b0;
    ndv = 0;
    for (int c = 1; c <= 26; c++) begin
      blk_rstn = (c != 19);
      #1;
      if (blk_dvld) ndv++;
      if (c >= 19 && c <= 22) chk("abort_no_start", mul_start, 0);
      if (c == 20) chk("abort_lanes", blk_dout, 0);
      if (c == 21) chk("drain_busy", busy, 1);
      if (c == 22) chk("drain_exit", busy, 0);
      @(negedge clk);
    end
    blk_rstn = 1'b1;
    chk("abort_no_dvld", ndv, 0);
    run_job(12'd1, 0, 0, 1, -1, 0, -1, 12'd17, dc, dv);
    chk("post_abort_latency", dc, 15);
    chk("post_abort_dout", dv, EXP17);

    run_job(12'd1, 0, 0, 1, -1, 0, 5, 12'd17, dc, dv);
    chk("ignore_latency", dc, 15);
    chk("ignore_dout", dv, EXP17);

    run_job(12'd2, 1, 12'd3, 1, -1, 0, -1, 12'd3, dc, dv);
    chk("both_latency", dc, 15);
    chk("both_dout", dv, EXP3);

    // Asynchronous reset while a multiply is outstanding.
    mul_lat = 4;
    a_in = 12'd1;
    blk_drdy = 1'b1;
    @(negedge clk);
    blk_drdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dout", blk_dout, 128'h0001 << 112);
    rst = 1'b1;
    #1;
    chk("mid_rst_dout", blk_dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", {blk_kvld, blk_dvld, mul_start, mul_x, mul_y}, 0);
    @(negedge clk);
    rst = 1'b0;
    man_vld = 1'b1;
    @(negedge clk);
    man_vld = 1'b0;
    #1;
    chk("late_vld_busy", busy, 0);
    chk("late_vld_dout", blk_dout, 0);
    chk("late_vld_start", mul_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
